a_fifo: RTL and testbench



---
 rtl/a_fifo.sv | 68 ++++++
 tb/tb_a_fifo.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/a_fifo.sv
// Purpose : single-clock FIFO, C_DEPTH x C_WIDTH, full/empty flags, registered read port.
// Latency : write visible to the read side the edge after it lands; read data on o_rd_data right after the accepting edge.
// Backpr. : writes while o_full and reads while o_empty are dropped with no state change.
//
// Ports:
//   i_clk, i_rst_n       clock, asynchronous active-low reset
//   i_wen, i_wr_data     write request and data
//   o_full               C_DEPTH unread words held
//   i_ren                read request
//   o_empty              no unread words held
//   o_rd_data            registered read data, holds until the next accepted read
module a_fifo #(
  parameter int C_DEPTH = 64,
  parameter int C_WIDTH = 32
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_wen,
  input  logic [C_WIDTH-1:0] i_wr_data,
  output logic               o_full,
  input  logic               i_ren,
  output logic               o_empty,
  output logic [C_WIDTH-1:0] o_rd_data
);

  localparam int AW = $clog2(C_DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [C_WIDTH-1:0] mem [C_DEPTH];
  logic [AW:0]        wptr;
  logic [AW:0]        rptr;
  logic               wacc;
  logic               racc;

  // Pointers carry one extra wrap bit so equal addresses can be told apart
  // as empty (same lap) or full (writer one lap ahead).
  assign o_empty = (wptr == rptr);
  assign o_full  = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);

  // Accepts look at the pre-edge flags: full+both reads only, empty+both writes only.
  assign wacc = i_wen && !o_full;
  assign racc = i_ren && !o_empty;

  // Storage is deliberately left out of reset; stale contents are never
  // reachable because reset realigns the pointers.
  always_ff @(posedge i_clk) begin
    if (wacc) begin
      mem[wptr[AW-1:0]] <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wptr      <= '0;
      rptr      <= '0;
      o_rd_data <= '0;
    end else begin
      if (wacc) begin
        wptr <= wptr + PTR_ONE;
      end
      if (racc) begin
        o_rd_data <= mem[rptr[AW-1:0]];
        rptr      <= rptr + PTR_ONE;
      end
    end
  end

endmodule

// File: tb/tb_a_fifo.sv
// Purpose : self-checking bench for a_fifo against a queue-based reference model.
// Latency : checks outputs 1 ns after every rising edge.
// Backpr. : exercises overflow, underflow and simultaneous read/write at both limits.
module tb_a_fifo;

  localparam int DEPTH = 64;
  localparam int WIDTH = 32;

  logic             i_clk = 1'b0;
  logic             i_rst_n;
  logic             i_wen;
  logic [WIDTH-1:0] i_wr_data;
  logic             o_full;
  logic             i_ren;
  logic             o_empty;
  logic [WIDTH-1:0] o_rd_data;

  a_fifo #(.C_DEPTH(DEPTH), .C_WIDTH(WIDTH)) dut (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_wen     (i_wen),
    .i_wr_data (i_wr_data),
    .o_full    (o_full),
    .i_ren     (i_ren),
    .o_empty   (o_empty),
    .o_rd_data (o_rd_data)
  );

  always #5 i_clk = ~i_clk;

  // Reference model: a queue of unread words plus the last word handed out.
  logic [WIDTH-1:0] model_q[$];
  logic [WIDTH-1:0] model_rd;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".empty"}, 64'(o_empty), 64'(model_q.size() == 0));
    check({tag, ".full"},  64'(o_full),  64'(model_q.size() == DEPTH));
    check({tag, ".rd"},    64'(o_rd_data), 64'(model_rd));
  endtask

  // Drive one cycle's request, let the edge happen, update the model with
  // the pre-edge occupancy, then compare.
  task automatic cycle(input logic wen, input logic ren, input logic [WIDTH-1:0] data,
                       input string tag);
    bit was_full;
    bit was_empty;
    i_wen     = wen;
    i_ren     = ren;
    i_wr_data = data;
    was_full  = (model_q.size() == DEPTH);
    was_empty = (model_q.size() == 0);
    @(posedge i_clk);
    if (ren && !was_empty) model_rd = model_q.pop_front();
    if (wen && !was_full)  model_q.push_back(data);
    #1;
    check_outputs(tag);
  endtask

  task automatic model_reset();
    model_q.delete();
    model_rd = '0;
  endtask

  initial begin
    int pw;
    int pr;
    i_rst_n   = 1'b0;
    i_wen     = 1'b0;
    i_ren     = 1'b0;
    i_wr_data = '0;
    model_reset();

    // Reset with the clock running.
    repeat (3) @(posedge i_clk);
    #1;
    check_outputs("reset");
    #2 i_rst_n = 1'b1;
    cycle(1'b0, 1'b0, '0, "post_reset_idle");
    cycle(1'b0, 1'b0, '0, "post_reset_idle2");

    // Fill with 1..64, then an overflow attempt.
    for (int i = 1; i <= DEPTH; i++) cycle(1'b1, 1'b0, WIDTH'(i), "fill");
    check("fill_full_flag", 64'(o_full), 64'd1);
    cycle(1'b1, 1'b0, 32'hDEAD_BEEF, "overflow");

    // Full with both requests: read wins, write dropped.
    cycle(1'b1, 1'b1, 32'hCAFE_0001, "full_both");
    check("full_both_rd", 64'(o_rd_data), 64'd1);
    // Refill the slot so the drain still shows the 1..64 tail intact.
    cycle(1'b1, 1'b0, 32'h0000_0041, "refill");

    // Drain everything in order.
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, '0, "drain");
    check("drain_last", 64'(o_rd_data), 64'h41);

    // Underflow: reads on empty are ignored, data holds.
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, '0, "underflow");
    check("underflow_hold", 64'(o_rd_data), 64'h41);

    // Empty with both requests: write accepted, read ignored.
    cycle(1'b1, 1'b1, 32'h1234_5678, "empty_both");
    check("empty_both_rd_hold", 64'(o_rd_data), 64'h41);
    cycle(1'b0, 1'b1, '0, "empty_both_read");
    check("empty_both_data", 64'(o_rd_data), 64'h1234_5678);

    // Prime 10, then stream both ways across pointer wrap.
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, WIDTH'($urandom), "prime");
    for (int i = 0; i < 200; i++) cycle(1'b1, 1'b1, WIDTH'($urandom), "stream");
    check("stream_occupancy", 64'(model_q.size()), 64'd10);

    // Random phases biased toward filling, then draining, then balanced.
    for (int ph = 0; ph < 6; ph++) begin
      case (ph % 3)
        0:       begin pw = 85; pr = 25; end
        1:       begin pw = 25; pr = 85; end
        default: begin pw = 60; pr = 60; end
      endcase
      for (int i = 0; i < 300; i++)
        cycle($urandom_range(0, 99) < pw, $urandom_range(0, 99) < pr,
              WIDTH'($urandom), "random");
    end

    // Mid-operation reset, asserted and released between edges.
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0, WIDTH'($urandom), "pre_rst_fill");
    cycle(1'b0, 1'b1, '0, "pre_rst_read");
    i_wen = 1'b0;
    i_ren = 1'b0;
    #1 i_rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs("async_rst");
    #2 i_rst_n = 1'b1;
    cycle(1'b1, 1'b0, 32'h5, "post_rst_write");
    cycle(1'b0, 1'b1, '0, "post_rst_read");
    check("post_rst_data", 64'(o_rd_data), 64'h5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Hard stop in case something stalls the main sequence.
  initial begin
    #200000;
    $display("FAIL timeout: got still running expected finished");
    $fatal(1, "timeout");
  end

endmodule
